// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage.
//
// Owns the fetch PC, drives it to instruction memory and to the BTB lookup
// port, and on every accepted instruction (fire) pushes
// {pc, instr, pred_taken, pred_target} into a DEPTH-entry first-word-fall-through
// queue feeding decode. Next PC is the BTB target when the BTB hits and predicts
// taken, otherwise pc+4. A redirect from branch resolution flushes the queue and
// reloads the PC; halt parks the fetcher until the next redirect.
//
// Parameters:
//   DEPTH     fetch queue entries (power of 2, >= 2)
//   RESET_PC  PC loaded on reset
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   imem_ren/imem_addr         instruction read request and address (== pc_fetch)
//   imem_rdata/ihit            instruction word and its valid strobe
//   pc_fetch                   current fetch PC, to BTB lookup
//   btb_hit/btb_pred_target/btb_pred_outcome   BTB lookup result for pc_fetch
//   redirect/redirect_pc       resolution-stage redirect pulse and target
//   halt                       stop fetching
//   deq_valid/deq_ready        queue head handshake to decode
//   deq_pc/deq_instr/deq_pred_taken/deq_pred_target   queue head contents
//   q_count                    queue occupancy
// Build option:
//   FETCH_PERF_EN  adds perf_fetched / perf_redirects 32-bit event counters.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   nRST,
  output logic                   imem_ren,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   ihit,
  output logic [31:0]            pc_fetch,
  input  logic                   btb_hit,
  input  logic [31:0]            btb_pred_target,
  input  logic                   btb_pred_outcome,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [31:0]            deq_pc,
  output logic [31:0]            deq_instr,
  output logic                   deq_pred_taken,
  output logic [31:0]            deq_pred_target,
  output logic [$clog2(DEPTH):0] q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_redirects
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  state_t          state, state_next;
  logic [31:0]     pc;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;

  logic [31:0]     mem_pc     [DEPTH];
  logic [31:0]     mem_instr  [DEPTH];
  logic            mem_taken  [DEPTH];
  logic [31:0]     mem_target [DEPTH];

  logic            taken;
  logic [31:0]     npc;
  logic            fire;
  logic            pop;

  // Fetch control and next-state logic.
  always_comb begin
    taken      = btb_hit && btb_pred_outcome;
    npc        = taken ? btb_pred_target : pc + 32'd4;
    imem_ren   = (state == RUN) && (count != FULL_COUNT) && !redirect;
    // halt suppresses the same-cycle fire even though the request is out.
    fire       = imem_ren && ihit && !halt;
    // A pop coinciding with a redirect is moot: the queue is being cleared.
    pop        = deq_valid && deq_ready && !redirect;
    count_next = count;
    if (fire && !pop)
      count_next = count + CW'(1);
    else if (pop && !fire)
      count_next = count - CW'(1);

    state_next = state;
    if (redirect)
      state_next = RUN;
    else if (halt)
      state_next = HALT;
    else if (state != HALT)
      // Looking at the post-update count lets a pop in a full cycle
      // re-enable fetch on the very next cycle.
      state_next = (count_next == FULL_COUNT) ? STALL : RUN;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc     <= redirect_pc;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (fire) begin
          pc     <= npc;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count_next;
      end
    end
  end

  // Queue storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge CLK) begin
    if (fire) begin
      mem_pc[wr_ptr]     <= pc;
      mem_instr[wr_ptr]  <= imem_rdata;
      mem_taken[wr_ptr]  <= taken;
      mem_target[wr_ptr] <= npc;
    end
  end

  always_comb begin
    imem_addr       = pc;
    pc_fetch        = pc;
    q_count         = count;
    deq_valid       = (count != '0);
    deq_pc          = deq_valid ? mem_pc[rd_ptr]     : 32'd0;
    deq_instr       = deq_valid ? mem_instr[rd_ptr]  : 32'd0;
    deq_pred_taken  = deq_valid ? mem_taken[rd_ptr]  : 1'b0;
    deq_pred_target = deq_valid ? mem_target[rd_ptr] : 32'd0;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (fire)
        perf_fetched <= perf_fetched + 32'd1;
      if (redirect)
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`else
  // Event counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit - scoreboard bench for fetch_unit.
// Stimulus drives directed cycles and pushes the expected queue entry whenever a
// fire is expected; a negedge monitor pops and compares on each dequeue.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ihit;
  logic [31:0] pc_fetch;
  logic        btb_hit;
  logic [31:0] btb_pred_target;
  logic        btb_pred_outcome;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_pred_taken;
  logic [31:0] deq_pred_target;
  logic [2:0]  q_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  int checks = 0;
  int fails  = 0;
  logic [96:0] exp_q[$];
  logic [31:0] exp_pc = 32'h0;
  int n_fire  = 0;
  int n_redir = 0;
  localparam logic [31:0] Z = 32'h0;

  always #5 CLK = ~CLK;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ihit(ihit),
    .pc_fetch(pc_fetch), .btb_hit(btb_hit), .btb_pred_target(btb_pred_target),
    .btb_pred_outcome(btb_pred_outcome), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_instr(deq_instr), .deq_pred_taken(deq_pred_taken),
    .deq_pred_target(deq_pred_target), .q_count(q_count)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every dequeue must match the oldest expected entry.
  always @(negedge CLK) begin
    if (nRST && deq_valid && deq_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL deq_unexpected: got pc %h with empty scoreboard", deq_pc);
      end else begin
        logic [96:0] e;
        logic [96:0] a;
        e = exp_q.pop_front();
        a = {deq_pc, deq_instr, deq_pred_taken, deq_pred_target};
        if (a !== e) begin
          fails++;
          $display("FAIL deq_entry: got %h expected %h", a, e);
        end else
          $display("deq pc=%h instr=%h taken=%0b target=%h", deq_pc, deq_instr,
                   deq_pred_taken, deq_pred_target);
      end
    end
  end

  // One cycle: drive inputs, check request side at negedge, update model after posedge.
  task automatic cyc(input logic ih, input logic bh, input logic bo, input logic [31:0] bt,
                     input logic rdy, input logic hl, input logic rd, input logic [31:0] rpc,
                     input logic exp_ren, input int exp_cnt);
    logic        tk;
    logic [31:0] np;
    ihit = ih; btb_hit = bh; btb_pred_outcome = bo; btb_pred_target = bt;
    imem_rdata = exp_pc ^ 32'hDEAD_0000;
    deq_ready = rdy; halt = hl; redirect = rd; redirect_pc = rpc;
    @(negedge CLK);
    chk("imem_ren", {31'd0, imem_ren}, {31'd0, exp_ren});
    chk("pc_fetch", pc_fetch, exp_pc);
    if (exp_cnt >= 0) chk("q_count", 32'(q_count), 32'(exp_cnt));
    @(posedge CLK);
    #1;
    if (rd) begin
      exp_q.delete();
      exp_pc = rpc;
      n_redir++;
    end else if (exp_ren && ih && !hl) begin
      tk = bh && bo;
      np = tk ? bt : exp_pc + 32'd4;
      exp_q.push_back({exp_pc, exp_pc ^ 32'hDEAD_0000, tk, np});
      $display("fire pc=%h taken=%0b npc=%h", exp_pc, tk, np);
      exp_pc = np;
      n_fire++;
    end
  endtask

  initial begin
    nRST = 1'b0; ihit = 0; btb_hit = 0; btb_pred_outcome = 0; btb_pred_target = 0;
    imem_rdata = 0; deq_ready = 0; halt = 0; redirect = 0; redirect_pc = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_imem_ren", {31'd0, imem_ren}, 32'd1);
    chk("rst_pc", pc_fetch, 32'h0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("rst_deq_pc", deq_pc, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Sequential fetch, decode always ready.
    cyc(1,0,0,Z,1,0,0,Z,1,0);
    for (int i = 0; i < 5; i++) cyc(1,0,0,Z,1,0,0,Z,1,1);

    // BTB taken to 0x40 at 0x8, then a not-taken hit at 0x44.
    cyc(0,0,0,Z,1,0,1,32'h8,0,1);
    cyc(1,1,1,32'h40,1,0,0,Z,1,0);
    cyc(1,0,0,Z,1,0,0,Z,1,1);
    cyc(1,1,0,32'h80,1,0,0,Z,1,1);
    cyc(1,0,0,Z,1,0,0,Z,1,1);

    // Fill the queue with decode stalled, then release one entry.
    cyc(0,0,0,Z,1,0,1,32'h1000,0,1);
    cyc(1,0,0,Z,0,0,0,Z,1,0);
    cyc(1,0,0,Z,0,0,0,Z,1,1);
    cyc(1,0,0,Z,0,0,0,Z,1,2);
    cyc(1,0,0,Z,0,0,0,Z,1,3);
    cyc(1,0,0,Z,0,0,0,Z,0,4);
    cyc(1,0,0,Z,1,0,0,Z,0,4);
    cyc(1,0,0,Z,1,0,0,Z,1,3);

    // Redirect with three queued entries and a same-cycle ihit.
    cyc(1,0,0,Z,0,0,1,32'h100,0,3);
    chk("redir_q_count", 32'(q_count), 32'd0);
    chk("redir_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("redir_pc", pc_fetch, 32'h100);

    // Halt: fetch stops, queue drains, redirect resumes.
    cyc(0,0,0,Z,1,0,0,Z,1,0);
    cyc(1,0,0,Z,0,0,0,Z,1,0);
    cyc(1,0,0,Z,0,0,0,Z,1,1);
    cyc(1,0,0,Z,0,1,0,Z,1,2);
    cyc(1,0,0,Z,1,0,0,Z,0,2);
    cyc(1,0,0,Z,1,0,0,Z,0,1);
    cyc(1,0,0,Z,1,0,0,Z,0,0);
    cyc(1,0,0,Z,1,0,1,32'h200,0,0);
    cyc(1,0,0,Z,1,0,0,Z,1,0);
    cyc(1,0,0,Z,1,0,0,Z,1,1);
    cyc(0,0,0,Z,1,0,0,Z,1,1);

    // pc+4 wraps at 2^32.
    cyc(0,0,0,Z,1,0,1,32'hFFFF_FFFC,0,0);
    cyc(1,0,0,Z,1,0,0,Z,1,0);
    cyc(0,0,0,Z,1,0,0,Z,1,1);
    cyc(0,0,0,Z,1,0,0,Z,1,0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(n_fire));
    chk("perf_redirects", perf_redirects, 32'(n_redir));
`endif

    // Asynchronous reset mid-run.
    ihit = 0;
    cyc(1,0,0,Z,0,0,0,Z,1,0);
    nRST = 1'b0;
    #1;
    chk("rst2_pc", pc_fetch, 32'h0);
    chk("rst2_q_count", 32'(q_count), 32'd0);
    chk("rst2_deq_valid", {31'd0, deq_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst2_perf_fetched", perf_fetched, 32'd0);
    chk("rst2_perf_redirects", perf_redirects, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
